// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: coin credit against runtime per-item prices,
// per-item stock, product then change dispensed over ready/valid handshakes.
module vend_ctrl_multi #(
    parameter int NUM_ITEMS  = 4,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 40,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            coin_valid,
    input  logic [CREDIT_W-1:0]             coin_amt,
    output logic                            coin_reject,
    input  logic                            sel_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0]    sel_item,
    output logic                            sel_nak,
    input  logic                            cancel,
    input  logic [NUM_ITEMS*CREDIT_W-1:0]   price,
    input  logic                            restock_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0]    restock_item,
    input  logic [STOCK_W-1:0]              stock_val,
    output logic                            vend_valid,
    output logic [$clog2(NUM_ITEMS)-1:0]    vend_item,
    input  logic                            vend_ready,
    output logic                            chg_valid,
    output logic [2:0]                      chg_coin,
    input  logic                            chg_ready,
    output logic [CREDIT_W-1:0]             credit,
    output logic                            busy
);

    localparam int IW = $clog2(NUM_ITEMS);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CREDIT = 2'd1;
    localparam logic [1:0] S_VEND   = 2'd2;
    localparam logic [1:0] S_CHANGE = 2'd3;

    logic [1:0]          state;
    logic [1:0]          n_state;
    logic [CREDIT_W-1:0] n_credit;
    logic [CREDIT_W-1:0] vend_price;
    logic [CREDIT_W-1:0] n_vend_price;
    logic                n_coin_reject;
    logic                n_sel_nak;
    logic                n_vend_valid;
    logic [IW-1:0]       n_vend_item;
    logic                n_chg_valid;
    logic [2:0]          n_chg_coin;
    logic                vend_fire;
    logic                coin_blocked;

    logic [STOCK_W-1:0]  stock [NUM_ITEMS];
    logic [CREDIT_W-1:0] price_tab [NUM_ITEMS];

    logic [CREDIT_W:0]   coin_sum;
    logic                coin_present;
    logic                coin_fits;
    logic                sel_in_range;
    logic                sel_ok;
    logic                restock_in_range;
    logic [CREDIT_W-1:0] vend_rem;
    logic [CREDIT_W-1:0] chg_rem;

    // Largest change denomination not exceeding the remaining credit; the
    // one-hot code {4,2,1} doubles as the coin value in credit units.
    function automatic logic [2:0] denom(input logic [CREDIT_W-1:0] c);
        if (c >= CREDIT_W'(4))
            return 3'b100;
        else if (c >= CREDIT_W'(2))
            return 3'b010;
        else if (c != '0)
            return 3'b001;
        else
            return 3'b000;
    endfunction

    genvar g;
    generate
        for (g = 0; g < NUM_ITEMS; g++) begin : g_price
            assign price_tab[g] = price[g*CREDIT_W +: CREDIT_W];
        end
    endgenerate

    // Sum one bit wider than credit so the ceiling check cannot wrap.
    assign coin_sum         = {1'b0, credit} + {1'b0, coin_amt};
    assign coin_present     = coin_valid && (coin_amt != '0);
    assign coin_fits        = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);
    assign sel_in_range     = int'(sel_item) < NUM_ITEMS;
    assign restock_in_range = int'(restock_item) < NUM_ITEMS;
    assign sel_ok           = sel_in_range && (credit >= price_tab[sel_item])
                              && (stock[sel_item] != '0);
    assign vend_rem         = credit - vend_price;
    assign chg_rem          = credit - CREDIT_W'(chg_coin);

    always_comb begin
        n_state       = state;
        n_credit      = credit;
        n_coin_reject = 1'b0;
        n_sel_nak     = 1'b0;
        n_vend_valid  = vend_valid;
        n_vend_item   = vend_item;
        n_vend_price  = vend_price;
        n_chg_valid   = chg_valid;
        n_chg_coin    = chg_coin;
        vend_fire     = 1'b0;
        coin_blocked  = 1'b0;

        case (state)
            S_IDLE, S_CREDIT: begin
                // cancel outranks selection, which outranks the coin
                if (state == S_CREDIT && cancel) begin
                    n_state      = S_CHANGE;
                    n_chg_valid  = 1'b1;
                    n_chg_coin   = denom(credit);
                    coin_blocked = 1'b1;
                end else if (sel_valid) begin
                    if (state == S_CREDIT && sel_ok) begin
                        n_state      = S_VEND;
                        n_vend_valid = 1'b1;
                        n_vend_item  = sel_item;
                        n_vend_price = price_tab[sel_item];
                        coin_blocked = 1'b1;
                    end else begin
                        n_sel_nak = 1'b1;
                    end
                end

                if (coin_present) begin
                    if (!coin_blocked && coin_fits) begin
                        n_credit = coin_sum[CREDIT_W-1:0];
                        if (state == S_IDLE)
                            n_state = S_CREDIT;
                    end else begin
                        n_coin_reject = 1'b1;
                    end
                end
            end

            S_VEND: begin
                n_coin_reject = coin_present;
                if (vend_valid && vend_ready) begin
                    vend_fire    = 1'b1;
                    n_vend_valid = 1'b0;
                    n_credit     = vend_rem;
                    if (vend_rem != '0) begin
                        n_state     = S_CHANGE;
                        n_chg_valid = 1'b1;
                        n_chg_coin  = denom(vend_rem);
                    end else begin
                        n_state = S_IDLE;
                    end
                end
            end

            S_CHANGE: begin
                n_coin_reject = coin_present;
                if (chg_valid && chg_ready) begin
                    n_credit = chg_rem;
                    if (chg_rem == '0) begin
                        n_state     = S_IDLE;
                        n_chg_valid = 1'b0;
                        n_chg_coin  = 3'b000;
                    end else begin
                        n_chg_coin = denom(chg_rem);
                    end
                end
            end

            default: begin
                n_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            credit      <= '0;
            coin_reject <= 1'b0;
            sel_nak     <= 1'b0;
            vend_valid  <= 1'b0;
            vend_item   <= '0;
            chg_valid   <= 1'b0;
            chg_coin    <= 3'b000;
            busy        <= 1'b0;
            for (int i = 0; i < NUM_ITEMS; i++)
                stock[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            state       <= n_state;
            credit      <= n_credit;
            coin_reject <= n_coin_reject;
            sel_nak     <= n_sel_nak;
            vend_valid  <= n_vend_valid;
            vend_item   <= n_vend_item;
            chg_valid   <= n_chg_valid;
            chg_coin    <= n_chg_coin;
            busy        <= (n_state == S_VEND) || (n_state == S_CHANGE);
            if (vend_fire)
                stock[vend_item] <= stock[vend_item] - STOCK_W'(1);
            // later assignment wins, so a restock overrides a same-item vend
            if (restock_valid && restock_in_range)
                stock[restock_item] <= stock_val;
        end
    end

    // Price captured at select time; only meaningful while in VEND.
    always_ff @(posedge clk) begin
        vend_price <= n_vend_price;
    end

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Scoreboard bench for vend_ctrl_multi: stimulus queues expected events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_vend_ctrl_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        coin_valid;
    logic [7:0]  coin_amt;
    logic        coin_reject;
    logic        sel_valid;
    logic [1:0]  sel_item;
    logic        sel_nak;
    logic        cancel;
    logic [31:0] price;
    logic        restock_valid;
    logic [1:0]  restock_item;
    logic [3:0]  stock_val;
    logic        vend_valid;
    logic [1:0]  vend_item;
    logic        vend_ready;
    logic        chg_valid;
    logic [2:0]  chg_coin;
    logic        chg_ready;
    logic [7:0]  credit;
    logic        busy;

    typedef struct {
        int a;
        int c;
    } ev_t;

    ev_t q_rej[$];
    ev_t q_nak[$];
    ev_t q_vend[$];
    ev_t q_chg[$];

    int n_checks = 0;
    int n_fail   = 0;

    vend_ctrl_multi dut (
        .clk(clk), .rst(rst),
        .coin_valid(coin_valid), .coin_amt(coin_amt), .coin_reject(coin_reject),
        .sel_valid(sel_valid), .sel_item(sel_item), .sel_nak(sel_nak),
        .cancel(cancel), .price(price),
        .restock_valid(restock_valid), .restock_item(restock_item), .stock_val(stock_val),
        .vend_valid(vend_valid), .vend_item(vend_item), .vend_ready(vend_ready),
        .chg_valid(chg_valid), .chg_coin(chg_coin), .chg_ready(chg_ready),
        .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event, value %0d, nothing expected (t=%0t)", name, act, $time);
    endtask

    // Monitor: events are sampled on the falling edge, half a cycle from the active edge.
    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            if (coin_reject) begin
                if (q_rej.size() == 0) unexpected("coin_reject", int'(credit));
                else begin
                    e = q_rej.pop_front();
                    check("rej_credit", int'(credit), e.c);
                end
            end
            if (sel_nak) begin
                if (q_nak.size() == 0) unexpected("sel_nak", int'(credit));
                else begin
                    e = q_nak.pop_front();
                    check("nak_credit", int'(credit), e.c);
                end
            end
            if (vend_valid && vend_ready) begin
                if (q_vend.size() == 0) unexpected("vend", int'(vend_item));
                else begin
                    e = q_vend.pop_front();
                    check("vend_item", int'(vend_item), e.a);
                    check("vend_credit", int'(credit), e.c);
                end
            end
            if (chg_valid && chg_ready) begin
                if (q_chg.size() == 0) unexpected("chg", int'(chg_coin));
                else begin
                    e = q_chg.pop_front();
                    check("chg_coin", int'(chg_coin), e.a);
                    check("chg_credit", int'(credit), e.c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input int a);
        coin_valid = 1'b1;
        coin_amt   = 8'(a);
        tick();
        coin_valid = 1'b0;
        coin_amt   = '0;
    endtask

    task automatic sel(input int i);
        sel_valid = 1'b1;
        sel_item  = 2'(i);
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic sel_and_coin(input int i, input int a);
        sel_valid  = 1'b1;
        sel_item   = 2'(i);
        coin_valid = 1'b1;
        coin_amt   = 8'(a);
        tick();
        sel_valid  = 1'b0;
        coin_valid = 1'b0;
        coin_amt   = '0;
    endtask

    task automatic cancel_req();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic restock(input int i, input int v);
        restock_valid = 1'b1;
        restock_item  = 2'(i);
        stock_val     = 4'(v);
        tick();
        restock_valid = 1'b0;
    endtask

    task automatic push_rej(input int c);
        q_rej.push_back('{a: 0, c: c});
    endtask
    task automatic push_nak(input int c);
        q_nak.push_back('{a: 0, c: c});
    endtask
    task automatic push_vend(input int item, input int c);
        q_vend.push_back('{a: item, c: c});
    endtask
    task automatic push_chg(input int cn, input int c);
        q_chg.push_back('{a: cn, c: c});
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (!busy && !vend_valid && !chg_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: still busy after 60 cycles, busy=%0d credit=%0d", name, busy, credit);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        coin_valid    = 1'b0;
        coin_amt      = '0;
        sel_valid     = 1'b0;
        sel_item      = '0;
        cancel        = 1'b0;
        restock_valid = 1'b0;
        restock_item  = '0;
        stock_val     = '0;
        vend_ready    = 1'b1;
        chg_ready     = 1'b1;
        price         = {8'd12, 8'd10, 8'd3, 8'd5};

        repeat (2) @(posedge clk);
        #1;
        check("rst_credit", int'(credit), 0);
        check("rst_vend_valid", int'(vend_valid), 0);
        check("rst_chg_valid", int'(chg_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_coin_reject", int'(coin_reject), 0);
        rst = 1'b0;
        tick();

        // IDLE behaviour: zero coin ignored, sel naks, cancel ignored
        coin(0);
        check("zero_coin_credit", int'(credit), 0);
        push_nak(0);
        sel(0);
        cancel_req();
        check("idle_cancel_busy", int'(busy), 0);
        check("idle_cancel_chg", int'(chg_valid), 0);

        // 1: exact payment, no change
        coin(2); check("t1_credit_a", int'(credit), 2);
        coin(2); check("t1_credit_b", int'(credit), 4);
        coin(1); check("t1_credit_c", int'(credit), 5);
        push_vend(0, 5);
        sel(0);
        check("t1_vend_valid", int'(vend_valid), 1);
        wait_idle("t1_idle");
        check("t1_credit_end", int'(credit), 0);

        // 2: one 20c change coin
        coin(5); coin(2);
        check("t2_credit", int'(credit), 7);
        push_vend(1, 7);
        push_chg(4, 4);
        sel(1);
        wait_idle("t2_idle");
        check("t2_credit_end", int'(credit), 0);

        // 3: cancel refund with a stalled hopper
        coin(5); coin(2);
        chg_ready = 1'b0;
        cancel_req();
        for (int k = 0; k < 3; k++) begin
            check("t3_hold_valid", int'(chg_valid), 1);
            check("t3_hold_coin", int'(chg_coin), 4);
            check("t3_hold_credit", int'(credit), 7);
            tick();
        end
        push_chg(4, 7); push_chg(2, 3); push_chg(1, 1);
        chg_ready = 1'b1;
        wait_idle("t3_idle");
        check("t3_credit_end", int'(credit), 0);

        // 4: credit ceiling and coin rejected under an accepted select
        coin(20); coin(18);
        check("t4_credit", int'(credit), 38);
        push_rej(38);
        coin(5);
        check("t4_credit_kept", int'(credit), 38);
        push_rej(38);
        push_vend(2, 38);
        for (int c = 28; c > 0; c -= 4) push_chg(4, c);
        sel_and_coin(2, 5);
        wait_idle("t4_idle");
        check("t4_credit_end", int'(credit), 0);

        // 5: out-of-stock and underfunded naks, coin during VEND
        restock(2, 0);
        coin(10);
        push_nak(10);
        sel(2);
        check("t5_credit_kept", int'(credit), 10);
        push_nak(10);
        sel(3);
        vend_ready = 1'b0;
        sel(0);
        check("t5_vend_valid", int'(vend_valid), 1);
        check("t5_vend_item", int'(vend_item), 0);
        push_rej(10);
        coin(5);
        check("t5_vend_hold", int'(vend_valid), 1);
        check("t5_credit_vend", int'(credit), 10);
        push_vend(0, 10);
        push_chg(4, 5); push_chg(1, 1);
        vend_ready = 1'b1;
        wait_idle("t5_idle");

        // stock decrements on vend: restock to 1, buy once, second try refused
        restock(1, 1);
        coin(3);
        push_vend(1, 3);
        sel(1);
        wait_idle("sd_idle");
        coin(3);
        push_nak(3);
        sel(1);
        push_chg(2, 3); push_chg(1, 1);
        cancel_req();
        wait_idle("sd_refund");

        // 6: asynchronous reset mid-CHANGE
        coin(3);
        chg_ready = 1'b0;
        cancel_req();
        check("t6_chg_valid", int'(chg_valid), 1);
        check("t6_chg_coin", int'(chg_coin), 2);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_credit", int'(credit), 0);
        check("t6_rst_chg_valid", int'(chg_valid), 0);
        check("t6_rst_chg_coin", int'(chg_coin), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_vend_valid", int'(vend_valid), 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        chg_ready = 1'b1;
        tick();
        check("t6_idle_busy", int'(busy), 0);
        coin(10);
        push_vend(2, 10);
        sel(2);
        wait_idle("t6_idle");
        check("t6_credit_end", int'(credit), 0);

        repeat (3) tick();
        check("left_rej", q_rej.size(), 0);
        check("left_nak", q_nak.size(), 0);
        check("left_vend", q_vend.size(), 0);
        check("left_chg", q_chg.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
Parametrised multi-product vending controller. Successor to the single-price, single-product vending FSM.
- Accumulates coin credit against per-item prices supplied at runtime.
- Tracks per-item stock.
- Hands out the product and then change over ready/valid handshakes.
- Supports cancel/refund.
- Sits between the coin acceptor front end and the dispenser/change-hopper drivers.

Parameters:
NUM_ITEMS, 4, number of selectable products (>=2)
CREDIT_W, 8, width of credit and price values; unit = 5 cents
MAX_CREDIT, 40, credit ceiling in units; coins that would exceed it are rejected
STOCK_W, 4, width of each per-item stock counter
INIT_STOCK, 10, stock value loaded into every item on reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
coin_valid  in  1  coin present this cycle
coin_amt  in  CREDIT_W  coin value in units; 0 is ignored
coin_reject  out  1  registered 1-cycle pulse: coin returned
sel_valid  in  1  product selection request
sel_item  in  $clog2(NUM_ITEMS)  selected item index
sel_nak  out  1  registered 1-cycle pulse: selection refused
cancel  in  1  refund request
price  in  NUM_ITEMS*CREDIT_W  flat price table; item i at [i*CREDIT_W +: CREDIT_W]
restock_valid  in  1  load stock_val into the restock_item counter
restock_item  in  $clog2(NUM_ITEMS)  item index to restock
stock_val  in  STOCK_W  new stock count
vend_valid  out  1  product dispense request
vend_item  out  $clog2(NUM_ITEMS)  item being dispensed
vend_ready  in  1  dispenser accepts
chg_valid  out  1  change coin request
chg_coin  out  3  one-hot denomination {20c,10c,5c} = {4,2,1} units
chg_ready  in  1  hopper accepts
credit  out  CREDIT_W  current credit
busy  out  1  high in VEND or CHANGE

Behaviour:
Reset:
- Asynchronous: rst (active-high, asynchronous); clock clk.
- state = IDLE; credit, coin_reject, sel_nak, vend_valid, chg_valid, chg_coin, vend_item and busy all 0; every stock counter = INIT_STOCK.
- Reset mid-operation discards credit and any pending vend/change.

States: IDLE (credit==0), CREDIT, VEND, CHANGE.

Coin handling:
- Coins are accepted only in IDLE or CREDIT.
- If coin_valid and coin_amt!=0 and credit+coin_amt<=MAX_CREDIT: credit updates next cycle. From IDLE the next state is CREDIT.
- Otherwise (over ceiling, or state VEND/CHANGE): credit is unchanged and coin_reject pulses the next cycle.
- The sum is computed at CREDIT_W+1 bits, so there is no wrap-around.

Selection (CREDIT only; in IDLE a sel_valid gives sel_nak):
- Accept if credit>=price[sel_item], stock[sel_item]!=0 and sel_item<NUM_ITEMS. Next state VEND; vend_item is latched.
- Otherwise sel_nak pulses and the state stays CREDIT.
- sel_valid in VEND or CHANGE is ignored (no nak).

Same-cycle priority: cancel > sel > coin.
- cancel in CREDIT goes to CHANGE with the full credit refund; any coin that cycle is rejected.
- An accepted sel rejects a same-cycle coin.
- A refused sel still lets the coin be accepted.
- cancel in IDLE, VEND or CHANGE is ignored.

Restock:
- Works in any state.
- If it hits the same item as a vend handshake in the same cycle, restock wins.

VEND:
- vend_valid=1 and vend_item is held stable until vend_ready.
- On the handshake: credit -= latched price (price captured at select time), stock[vend_item] -= 1, vend_valid drops.
- Next state is CHANGE if the remaining credit>0, else IDLE.

CHANGE:
- chg_valid=1; chg_coin = the largest denomination <= credit (4, then 2, then 1).
- On each chg_valid&chg_ready, credit -= denomination and chg_coin updates the next cycle.
- When credit reaches 0: chg_valid=0 and state is IDLE.
- One coin per handshake; chg_valid holds indefinitely while chg_ready is low.

Timing and overflow:
- All outputs are registered.
- Latency from select to vend_valid is 1 cycle; from the vend handshake to the first chg_valid is 1 cycle.
- Stock never underflows, because items at 0 are refused.

Test Plan:
1. price[0]=5; coins 2,2,1 then sel 0 -> credit 2,4,5; vend_valid with item 0 next cycle; vend_ready -> credit 0, stock[0]=9, IDLE, no chg_valid.
2. price[1]=3; coins 5,2 then sel 1, vend_ready, chg_ready held high -> chg_coin 4 (credit 4->0), then IDLE; exactly one change coin.
3. Credit 7, cancel -> chg_coin 4, 2, 1 on consecutive handshakes. With chg_ready low for 3 cycles, chg_valid and chg_coin are stable.
4. MAX_CREDIT=40, credit 38, coin 5 -> coin_reject pulse and credit stays 38. Same cycle as an accepted sel of price 10 -> VEND, coin rejected.
5. restock item 2 to 0, then credit 10 and sel 2 -> sel_nak, credit 10 kept; sel with credit<price also naks. Coin during VEND -> coin_reject.
6. Assert rst mid-CHANGE (credit 3) -> all outputs 0 immediately (asynchronous), stock back to INIT_STOCK, IDLE after release.
